trap_commit: RTL and testbench

//  Consumer of the trap-detection outputs (trap_en/cause/epc/val). Takes the trap: picks M or S target

---
 rtl/trap_pkg.sv | 38 +++
 rtl/trap_target_gen.sv | 27 ++
 rtl/trap_commit.sv | 196 +++++++++++++++++++
 tb/tb_trap_commit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants and types for the trap commit slice.
package trap_pkg;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned PRV_W      = 2;
  localparam int unsigned CODE_W     = 6;

  // Privilege encoding (matches the core-wide PRV_* definitions)
  localparam logic [PRV_W-1:0] PRV_U = 2'd0;
  localparam logic [PRV_W-1:0] PRV_S = 2'd1;
  localparam logic [PRV_W-1:0] PRV_M = 2'd3;

  // Owned CSR addresses
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL  = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_SEPC   = 12'h141;
  localparam logic [CSR_ADDR_W-1:0] CSR_SCAUSE = 12'h142;
  localparam logic [CSR_ADDR_W-1:0] CSR_STVAL  = 12'h143;

  // xTVEC mode field value selecting vectored interrupts
  localparam logic [1:0] TVEC_MODE_VEC = 2'd1;

  // FSM states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  // mstatus fields owned by this block
  typedef struct packed {
    logic             mie;
    logic             mpie;
    logic             sie;
    logic             spie;
    logic             spp;
    logic [PRV_W-1:0] mpp;
  } mstatus_t;

endpackage

// File: rtl/trap_target_gen.sv
// Computes the trap handler address from xTVEC and the trap cause.
module trap_target_gen
  import trap_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic [XLEN-1:0]   tvec,
  input  logic              intr,
  input  logic [CODE_W-1:0] code,
  output logic [ADDR_W-1:0] target_c
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] base;

  // Base is tvec with the mode bits cleared; vectored interrupts add code*4 (wraps)
  always_comb begin
    offset = '0;
    base   = ADDR_W'(tvec & ~XLEN'(3));
    if ((tvec[1:0] == TVEC_MODE_VEC) && intr) begin
      offset = ADDR_W'({code, 2'b00});
    end
    target_c = base + offset;
  end

endmodule

// File: rtl/trap_commit.sv
// Takes traps and xRET: owns trap CSRs, mstatus stack fields, current
// privilege, and issues a held PC redirect to the fetch/flush control.
module trap_commit
  import trap_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_en,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [ADDR_W-1:0]     trap_epc,
  input  logic [XLEN-1:0]       trap_val,
  input  logic                  mret,
  input  logic                  sret,
  input  logic [XLEN-1:0]       medeleg,
  input  logic [XLEN-1:0]       mideleg,
  input  logic [XLEN-1:0]       mtvec,
  input  logic [XLEN-1:0]       stvec,
  input  logic                  csr_wr,
  input  logic [CSR_ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]       csr_wdata,
  output logic [XLEN-1:0]       csr_rdata,
  output logic [PRV_W-1:0]      prv_cur,
  output logic                  mie_o,
  output logic                  sie_o,
  output logic [PRV_W-1:0]      mpp_o,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  redirect_ready
);

  logic [0:0]        state_q,  state_d;
  logic [PRV_W-1:0]  prv_q,    prv_d;
  mstatus_t          ms_q,     ms_d;
  logic [XLEN-1:0]   mepc_q,   mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mtval_q,  mtval_d;
  logic [XLEN-1:0]   sepc_q,   sepc_d;
  logic [XLEN-1:0]   scause_q, scause_d;
  logic [XLEN-1:0]   stval_q,  stval_d;
  logic              rv_q,     rv_d;
  logic [ADDR_W-1:0] rpc_q,    rpc_d;

  logic              intr_c;
  logic [CODE_W-1:0] code_c;
  logic              deleg_c;
  logic [XLEN-1:0]   tvec_c;
  logic [ADDR_W-1:0] trap_target_c;
  logic [XLEN-1:0]   epc_aligned_c;

  assign intr_c        = trap_cause[XLEN-1];
  assign code_c        = trap_cause[CODE_W-1:0];
  assign epc_aligned_c = XLEN'(trap_epc & ~ADDR_W'(3));

  // Delegate to S only when not already in M and the matching deleg bit is set
  always_comb begin
    deleg_c = 1'b0;
    if (prv_q != PRV_M) begin
      deleg_c = intr_c ? mideleg[code_c] : medeleg[code_c];
    end
    tvec_c = deleg_c ? stvec : mtvec;
  end

  trap_target_gen #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_target (
    .tvec     (tvec_c),
    .intr     (intr_c),
    .code     (code_c),
    .target_c (trap_target_c)
  );

  // Next-state logic: events are accepted only in IDLE, in priority order
  always_comb begin
    state_d  = state_q;
    prv_d    = prv_q;
    ms_d     = ms_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    sepc_d   = sepc_q;
    scause_d = scause_q;
    stval_d  = stval_q;
    rv_d     = rv_q;
    rpc_d    = rpc_q;

    if (state_q == ST_IDLE) begin
      if (trap_en) begin
        state_d = ST_REDIR;
        rv_d    = 1'b1;
        rpc_d   = trap_target_c;
        if (deleg_c) begin
          sepc_d   = epc_aligned_c;
          scause_d = trap_cause;
          stval_d  = trap_val;
          ms_d.spie = ms_q.sie;
          ms_d.sie  = 1'b0;
          ms_d.spp  = prv_q[0];
          prv_d     = PRV_S;
        end else begin
          mepc_d   = epc_aligned_c;
          mcause_d = trap_cause;
          mtval_d  = trap_val;
          ms_d.mpie = ms_q.mie;
          ms_d.mie  = 1'b0;
          ms_d.mpp  = prv_q;
          prv_d     = PRV_M;
        end
      end else if (mret) begin
        state_d   = ST_REDIR;
        rv_d      = 1'b1;
        rpc_d     = ADDR_W'(mepc_q);
        prv_d     = ms_q.mpp;
        ms_d.mie  = ms_q.mpie;
        ms_d.mpie = 1'b1;
        ms_d.mpp  = PRV_U;
      end else if (sret) begin
        state_d   = ST_REDIR;
        rv_d      = 1'b1;
        rpc_d     = ADDR_W'(sepc_q);
        prv_d     = {1'b0, ms_q.spp};
        ms_d.sie  = ms_q.spie;
        ms_d.spie = 1'b1;
        ms_d.spp  = 1'b0;
      end else if (csr_wr) begin
        case (csr_addr)
          CSR_MEPC:   mepc_d   = csr_wdata & ~XLEN'(3);
          CSR_MCAUSE: mcause_d = csr_wdata;
          CSR_MTVAL:  mtval_d  = csr_wdata;
          CSR_SEPC:   sepc_d   = csr_wdata & ~XLEN'(3);
          CSR_SCAUSE: scause_d = csr_wdata;
          CSR_STVAL:  stval_d  = csr_wdata;
          default:    ;
        endcase
      end
    end else begin
      if (redirect_ready) begin
        state_d = ST_IDLE;
        rv_d    = 1'b0;
      end
    end
  end

  // State and CSR registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prv_q    <= PRV_M;
      ms_q     <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      sepc_q   <= '0;
      scause_q <= '0;
      stval_q  <= '0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      prv_q    <= prv_d;
      ms_q     <= ms_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      sepc_q   <= sepc_d;
      scause_q <= scause_d;
      stval_q  <= stval_d;
      rv_q     <= rv_d;
      rpc_q    <= rpc_d;
    end
  end

  // CSR read mux, zero for addresses not owned here
  always_comb begin
    case (csr_addr)
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_q;
      CSR_SEPC:   csr_rdata = sepc_q;
      CSR_SCAUSE: csr_rdata = scause_q;
      CSR_STVAL:  csr_rdata = stval_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign prv_cur        = prv_q;
  assign mie_o          = ms_q.mie;
  assign sie_o          = ms_q.sie;
  assign mpp_o          = ms_q.mpp;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_commit.sv
// Self-checking bench for trap_commit: vector table plus corner-case sequences.
module tb_trap_commit;
  import trap_pkg::*;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;

  logic              clk;
  logic              rst;
  logic              trap_en;
  logic [XLEN-1:0]   trap_cause;
  logic [ADDR_W-1:0] trap_epc;
  logic [XLEN-1:0]   trap_val;
  logic              mret;
  logic              sret;
  logic [XLEN-1:0]   medeleg;
  logic [XLEN-1:0]   mideleg;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   stvec;
  logic              csr_wr;
  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic [1:0]        prv_cur;
  logic              mie_o;
  logic              sie_o;
  logic [1:0]        mpp_o;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              redirect_ready;

  trap_commit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_en        (trap_en),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .trap_val       (trap_val),
    .mret           (mret),
    .sret           (sret),
    .medeleg        (medeleg),
    .mideleg        (mideleg),
    .mtvec          (mtvec),
    .stvec          (stvec),
    .csr_wr         (csr_wr),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .prv_cur        (prv_cur),
    .mie_o          (mie_o),
    .sie_o          (sie_o),
    .mpp_o          (mpp_o),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  // kind: 0 = trap, 1 = mret, 2 = sret
  typedef struct {
    int          kind;
    logic [63:0] cause;
    logic [63:0] epc;
    logic [63:0] val;
    logic [63:0] medeleg;
    logic [63:0] mideleg;
    logic [63:0] mtvec;
    logic [63:0] stvec;
    logic [63:0] exp_pc;
    logic [1:0]  exp_prv;
    logic        exp_mie;
    logic [1:0]  exp_mpp;
    logic [11:0] a0;
    logic [63:0] d0;
    logic [11:0] a1;
    logic [63:0] d1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_check(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_wr    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_wr    = 1'b0;
  endtask

  // Wait (bounded) for a redirect and compare it with the scoreboard head
  task automatic expect_redirect(input string name);
    int n;
    logic [ADDR_W-1:0] e;
    n = 0;
    while (!redirect_valid && n < 8) begin
      tick();
      n++;
    end
    total++;
    if (!redirect_valid) begin
      bad++;
      $display("FAIL %s_timeout: no redirect_valid within 8 cycles", name);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: redirect pc %h with empty scoreboard", name, redirect_pc);
    end else begin
      e = exp_q.pop_front();
      if (redirect_pc !== e) begin
        bad++;
        $display("FAIL %s_pc: got %h expected %h", name, redirect_pc, e);
      end
    end
  endtask

  task automatic release_redirect(input string name);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check({name, "_release"}, 64'(redirect_valid), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm         = $sformatf("v%0d", idx);
    medeleg    = v.medeleg;
    mideleg    = v.mideleg;
    mtvec      = v.mtvec;
    stvec      = v.stvec;
    trap_cause = v.cause;
    trap_epc   = v.epc;
    trap_val   = v.val;
    trap_en    = (v.kind == 0);
    mret       = (v.kind == 1);
    sret       = (v.kind == 2);
    exp_q.push_back(v.exp_pc);
    tick();
    trap_en = 1'b0;
    mret    = 1'b0;
    sret    = 1'b0;
    expect_redirect(nm);
    check({nm, "_prv"}, 64'(prv_cur), 64'(v.exp_prv));
    check({nm, "_mie"}, 64'(mie_o), 64'(v.exp_mie));
    check({nm, "_mpp"}, 64'(mpp_o), 64'(v.exp_mpp));
    csr_check({nm, "_csr0"}, v.a0, v.d0);
    csr_check({nm, "_csr1"}, v.a1, v.d1);
    release_redirect(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          kind cause                   epc            val            medeleg                  mideleg  mtvec                   stvec          exp_pc                  prv mie mpp a0          d0                      a1          d1
    vecs[0] = '{0, 64'd11,                 64'h8000_0100, 64'h0,         64'h0,                   64'h0,   64'h8000_0000,          64'h8020_0000, 64'h8000_0000,          2'd3, 1'b0, 2'd3, CSR_MEPC,   64'h8000_0100,          CSR_MCAUSE, 64'd11};
    vecs[1] = '{1, 64'd0,                  64'h0,         64'h0,         64'h0,                   64'h0,   64'h8000_0000,          64'h8020_0000, 64'h8000_0100,          2'd3, 1'b0, 2'd0, CSR_MEPC,   64'h8000_0100,          CSR_MCAUSE, 64'd11};
    vecs[2] = '{1, 64'd0,                  64'h0,         64'h0,         64'h0,                   64'h0,   64'h8000_0000,          64'h8020_0000, 64'h8000_0400,          2'd0, 1'b1, 2'd0, CSR_MEPC,   64'h8000_0400,          CSR_MTVAL,  64'hdead_beef};
    vecs[3] = '{0, 64'd13,                 64'h1000_0046, 64'h0dead000,  64'h2000,                64'h0,   64'h8000_0000,          64'h8020_0000, 64'h8020_0000,          2'd1, 1'b1, 2'd0, CSR_SCAUSE, 64'd13,                 CSR_MEPC,   64'h8000_0400};
    vecs[4] = '{2, 64'd0,                  64'h0,         64'h0,         64'h2000,                64'h0,   64'h8000_0000,          64'h8020_0000, 64'h1000_0044,          2'd0, 1'b1, 2'd0, CSR_SEPC,   64'h1000_0044,          CSR_STVAL,  64'h0dead000};
    vecs[5] = '{0, 64'h8000_0000_0000_0007, 64'h1000_0048, 64'h0,        64'h2080,                64'h0,   64'h8000_0001,          64'h8020_0000, 64'h8000_001C,          2'd3, 1'b0, 2'd0, CSR_MCAUSE, 64'h8000_0000_0000_0007, CSR_MEPC,  64'h1000_0048};
    vecs[6] = '{0, 64'd13,                 64'h1000_004C, 64'h0,         64'h2000,                64'h0,   64'h8000_0001,          64'h8020_0000, 64'h8000_0000,          2'd3, 1'b0, 2'd3, CSR_MCAUSE, 64'd13,                 CSR_SEPC,   64'h1000_0044};
    vecs[7] = '{0, 64'h8000_0000_0000_0003, 64'h2000_0000, 64'h55,      64'h0,                   ~64'h0,  64'hFFFF_FFFF_FFFF_FFFD, 64'h8020_0000, 64'h0000_0000_0000_0008, 2'd3, 1'b0, 2'd3, CSR_MTVAL,  64'h55,                 CSR_MEPC,   64'h2000_0000};

    rst            = 1'b1;
    trap_en        = 1'b0;
    trap_cause     = '0;
    trap_epc       = '0;
    trap_val       = '0;
    mret           = 1'b0;
    sret           = 1'b0;
    medeleg        = '0;
    mideleg        = '0;
    mtvec          = '0;
    stvec          = '0;
    csr_wr         = 1'b0;
    csr_addr       = CSR_MEPC;
    csr_wdata      = '0;
    redirect_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_prv", 64'(prv_cur), 64'd3);
    check("rst_rv", 64'(redirect_valid), 64'd0);
    check("rst_pc", redirect_pc, 64'd0);
    check("rst_mpp", 64'(mpp_o), 64'd0);
    csr_check("rst_mepc", CSR_MEPC, 64'd0);

    run_vec(vecs[0], 0);
    run_vec(vecs[1], 1);

    // CSR writes: epc alignment, verbatim tval, unowned address ignored, no redirect
    csr_write(CSR_MEPC, 64'h8000_0403);
    check("wr_no_redirect", 64'(redirect_valid), 64'd0);
    csr_check("wr_mepc", CSR_MEPC, 64'h8000_0400);
    csr_write(CSR_MTVAL, 64'hdead_beef);
    csr_check("wr_mtval", CSR_MTVAL, 64'hdead_beef);
    csr_write(12'h300, 64'hffff);
    csr_check("wr_unowned", 12'h300, 64'd0);

    for (int i = 2; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Trap and mret together: trap wins; ready held low; later events ignored
    trap_en    = 1'b1;
    mret       = 1'b1;
    trap_cause = 64'd2;
    trap_epc   = 64'h3000;
    trap_val   = 64'h0;
    medeleg    = '0;
    mideleg    = '0;
    mtvec      = 64'h8000_0100;
    exp_q.push_back(64'h8000_0100);
    tick();
    trap_en = 1'b0;
    mret    = 1'b0;
    expect_redirect("race");
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        trap_en    = 1'b1;
        trap_cause = 64'd5;
        trap_epc   = 64'h4000;
      end
      if (c == 2) begin
        csr_wr    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = 64'h99;
      end
      tick();
      trap_en = 1'b0;
      csr_wr  = 1'b0;
      check($sformatf("hold%0d_rv", c), 64'(redirect_valid), 64'd1);
      check($sformatf("hold%0d_pc", c), redirect_pc, 64'h8000_0100);
    end
    csr_check("race_mcause", CSR_MCAUSE, 64'd2);
    csr_check("race_mepc", CSR_MEPC, 64'h3000);
    check("race_mpp", 64'(mpp_o), 64'd3);
    check("race_prv", 64'(prv_cur), 64'd3);
    release_redirect("race");

    // redirect_ready while idle does nothing
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("idle_ready_rv", 64'(redirect_valid), 64'd0);
    check("idle_ready_pc", redirect_pc, 64'h8000_0100);

    // Reset during a pending redirect
    trap_en    = 1'b1;
    trap_cause = 64'd11;
    trap_epc   = 64'h5000;
    tick();
    trap_en = 1'b0;
    check("mid_rv", 64'(redirect_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rv", 64'(redirect_valid), 64'd0);
    check("mid_rst_pc", redirect_pc, 64'd0);
    check("mid_rst_prv", 64'(prv_cur), 64'd3);
    csr_check("mid_rst_mepc", CSR_MEPC, 64'd0);
    csr_check("mid_rst_sepc", CSR_SEPC, 64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
